// File: rtl/multi_cycle_add_sub.sv
// multi_cycle_add_sub: WIDTH-bit adder/subtractor processing CHUNK bits per
// clock with a ripple carry held between chunks. start/busy/done handshake;
// s/c/o/z are registered on entry to DONE and held until the next result.
module multi_cycle_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             o,
    output logic             z
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum_ext;
    logic [WIDTH-1:0] next_acc;
    logic             msb_cin;

    // Select the current chunk, add it with the held carry and merge the
    // partial sum into the accumulator image; msb_cin is only meaningful on
    // the final chunk, where the top bit of the chunk is the result MSB.
    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        next_acc = acc;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
        sum_ext = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        for (int unsigned i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                next_acc[i*CHUNK +: CHUNK] = sum_ext[CHUNK-1:0];
            end
        end
        msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_ext[CHUNK-1];
    end

    // Control FSM with registered handshake outputs and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
            o     <= 1'b0;
            z     <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= next_acc;
                    carry <= sum_ext[CHUNK];
                    if (idx == LAST_IDX) begin
                        s     <= next_acc;
                        c     <= sum_ext[CHUNK];
                        o     <= msb_cin ^ sum_ext[CHUNK];
                        z     <= (next_acc == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_add_sub.sv
// Directed and randomised checks for multi_cycle_add_sub in three
// configurations: 16/4 (main), 8/8 (single chunk), 32/8 (random sweep).
module tb_multi_cycle_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 16-bit, 4-bit chunk instance
    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        busy16, done16, c16, o16, z16;

    multi_cycle_add_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .s(s16), .c(c16), .o(o16), .z(z16)
    );

    // 8-bit, single-chunk instance
    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        busy8, done8, c8, o8, z8;

    multi_cycle_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .s(s8), .c(c8), .o(o8), .z(z8)
    );

    // 32-bit, 8-bit chunk instance
    logic        start32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        busy32, done32, c32, o32, z32;

    multi_cycle_add_sub #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .s(s32), .c(c32), .o(o32), .z(z32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one edge; returns #1 after the accepting edge.
    task automatic start_op16(input logic sb, input logic [15:0] av, input logic [15:0] bv);
        start16 = 1'b1; sub16 = sb; a16 = av; b16 = bv;
        tick();
        start16 = 1'b0;
    endtask

    // Latency counts the acceptance cycle as 1; lat = 0 means timeout.
    task automatic wait_done16(output int lat, output int bcnt, output int overlap);
        lat = 0; bcnt = 0; overlap = 0;
        for (int k = 1; k <= 50; k++) begin
            if (busy16 && done16) overlap++;
            if (done16) begin
                lat = k;
                break;
            end
            if (busy16) bcnt++;
            tick();
        end
    endtask

    // Behavioural reference: plain two's-complement arithmetic on 33 bits.
    function automatic logic [34:0] model32(input logic sb, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] r;
        logic        ov;
        if (sb) r = {1'b0, x} - {1'b0, y};
        else    r = {1'b0, x} + {1'b0, y};
        if (sb) ov = (x[31] != y[31]) && (r[31] != x[31]);
        else    ov = (x[31] == y[31]) && (r[31] != x[31]);
        // For subtract, carry means "no borrow"
        return {sb ? ~r[32] : r[32], ov, (r[31:0] == 32'd0), r[31:0]};
    endfunction

    typedef struct {
        logic        sb;
        logic [15:0] av;
        logic [15:0] bv;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        logic        ez;
    } vec16_t;

    initial begin
        int lat, bcnt, ovl, dcount;
        vec16_t vecs[6];

        vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h0009, 16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset busy/done", {busy16, done16}, 2'b00);
        check("reset s", s16, 16'h0000);
        check("reset c/o/z", {c16, o16, z16}, 3'b000);

        // Directed add/sub vectors with latency and busy-length checks
        foreach (vecs[i]) begin
            start_op16(vecs[i].sb, vecs[i].av, vecs[i].bv);
            a16 = 16'hDEAD; b16 = 16'hBEEF; sub16 = ~vecs[i].sb;
            wait_done16(lat, bcnt, ovl);
            check($sformatf("vec%0d latency", i), lat, 5);
            check($sformatf("vec%0d busy cycles", i), bcnt, 4);
            check($sformatf("vec%0d overlap", i), ovl, 0);
            check($sformatf("vec%0d s", i), s16, vecs[i].es);
            check($sformatf("vec%0d c/o/z", i), {c16, o16, z16},
                  {vecs[i].ec, vecs[i].eo, vecs[i].ez});
            tick();
            check($sformatf("vec%0d done pulse width", i), done16, 1'b0);
            check($sformatf("vec%0d s held", i), s16, vecs[i].es);
        end

        // start during RUN is ignored
        start_op16(1'b0, 16'h1111, 16'h2222);
        tick();
        start16 = 1'b1; sub16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001;
        tick();
        start16 = 1'b0;
        check("during RUN s holds previous", s16, 16'h0000);
        wait_done16(lat, bcnt, ovl);
        check("ignore start latency", lat, 3);
        check("ignore start s", s16, 16'h3333);
        check("ignore start c/o/z", {c16, o16, z16}, 3'b000);

        // Back-to-back: start in the DONE cycle
        start_op16(1'b0, 16'h0100, 16'h0200);
        check("b2b busy immediately", {busy16, done16}, 2'b10);
        wait_done16(lat, bcnt, ovl);
        check("b2b latency", lat, 5);
        check("b2b s", s16, 16'h0300);
        tick();

        // Reset during the second RUN cycle discards the operation
        start_op16(1'b0, 16'h1234, 16'h1111);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun reset busy/done", {busy16, done16}, 2'b00);
        check("midrun reset s", s16, 16'h0000);
        check("midrun reset c/o/z", {c16, o16, z16}, 3'b000);
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            if (done16 || busy16) dcount++;
            tick();
        end
        check("no done after reset", dcount, 0);
        start_op16(1'b0, 16'h0001, 16'h0002);
        wait_done16(lat, bcnt, ovl);
        check("post-reset latency", lat, 5);
        check("post-reset s", s16, 16'h0003);

        // Single-chunk configuration
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h7F; b8 = 8'h01;
        tick();
        start8 = 1'b0;
        check("w8 busy after accept", {busy8, done8}, 2'b10);
        tick();
        check("w8 done at 2 cycles", {busy8, done8}, 2'b01);
        check("w8 s", s8, 8'h80);
        check("w8 c/o/z", {c8, o8, z8}, 3'b010);
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
        tick();
        start8 = 1'b0;
        tick();
        check("w8 sub done", done8, 1'b1);
        check("w8 sub s", s8, 8'h7F);
        check("w8 sub c/o/z", {c8, o8, z8}, 3'b110);
        tick();

        // Random sweep against the behavioural model
        for (int n = 0; n < 1000; n++) begin
            logic        rsb;
            logic [31:0] ra, rb;
            int          k;
            rsb = 1'($urandom_range(0, 1));
            ra  = $urandom();
            rb  = $urandom();
            if (n % 50 == 0) rb = ra;
            start32 = 1'b1; sub32 = rsb; a32 = ra; b32 = rb;
            tick();
            start32 = 1'b0;
            a32 = $urandom(); b32 = $urandom();
            for (k = 1; k <= 20 && !done32; k++) tick();
            check($sformatf("rand%0d latency", n), k, 5);
            check($sformatf("rand%0d %s %h %h", n, rsb ? "sub" : "add", ra, rb),
                  {c32, o32, z32, s32}, model32(rsb, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
